rob_retire: RTL and testbench
=============================

# rob_retire

In-order commit stage of the out-of-order core. It reads the 16-entry re-order buffer filled by dispatch and retires up to two completed entries per cycle from the head. For each retired entry it reports the entry index back to dispatch so the slot is cleared. It also returns the overwritten physical register to the free list and updates the committed architectural map.

## Interface
Parameters:
- ROB_DEPTH, 16: ROB entries; power of two.
- PHYS_W, 6: physical register index width.
- ARCH_W, 5: architectural register index width.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rob  in  19 x ROB_DEPTH  ROB entries. Entry layout:
  - [18] complete (unused; see complete_array)
  - [17:13] arch dest
  - [12:7] overwritten phys
  - [6:1] new dest phys
  - [0] valid
- complete_array  in  ROB_DEPTH  per-entry execution-complete flags.
- flush  in  1  synchronous pipeline flush.
- retire_valid  out  2  slot k retired this cycle.
- retire_rob  out  4 x 2  ROB index retired in slot k.
- free_valid  out  2  free_phys[k] is to be returned to the free list.
- free_phys  out  PHYS_W x 2  overwritten physical register being freed.
- commit_arch  out  ARCH_W x 2  arch register committed in slot k.
- commit_phys  out  PHYS_W x 2  physical register now architecturally mapped.
- head_idx  out  4  current ROB head.

## Operation
- Head pointer `head`, 4 bits, wraps 15 -> 0 by natural overflow.
- Retire conditions:
  - slot0 eligible: rob[head][0] and complete_array[head].
  - slot1 eligible: slot0 eligible, rob[head+1][0] and complete_array[head+1]. Index arithmetic is mod 16.
  - Slot1 never retires without slot0 (strict program order).
- For each retiring slot k:
  - retire_valid[k]=1, retire_rob[k] = index.
  - commit_arch/commit_phys = entry arch dest / new dest phys.
  - free_valid[k] = (arch dest != 0). free_phys[k] = overwritten phys.
- head advances by the number retired (0, 1 or 2).
- FSM states:
  - S_IDLE: head entry not valid.
  - S_WAIT: head valid but not complete.
  - S_COMMIT: at least one slot retiring.
  - State is recomputed every cycle from the head conditions.
  - S_FLUSH: entered for exactly one cycle on flush, then S_IDLE.
- Flush: head <= 0, all valid outputs 0 next cycle, no retirement that cycle even if eligible. Flush has priority over retirement.
- Consumers must gate retire_rob, free_phys and commit_* with their valid bits. Dispatch must clear rob[retire_rob[k]] only when retire_valid[k].

## Timing
- Registered outputs; 1-cycle latency. Eligibility sampled at edge N appears on outputs after edge N; head updates at the same edge.
- Dispatch clears retired entries at edge N+1. head has already moved past them, so an entry is never retired twice.
- Reset values (asynchronous):
  - head 0, state S_IDLE.
  - retire_valid, free_valid 0.
  - retire_rob, free_phys, commit_arch, commit_phys, head_idx all 0.
- Wrap-around: head=15 with 15 and 0 both eligible -> retire_rob = {15, 0}, head becomes 1.
- Reset mid-operation: outputs drop in the same cycle, no partial commit. Entries are not modified (rob is read-only here).
- X on complete_array of a valid entry is treated as not complete.

## Configuration
- ROB_RETIRE_STATS_EN:
  - Defined: adds output retired_count (32 bits, increments by retire_valid popcount) and stall_count (32 bits, increments on every cycle in S_WAIT). Both reset to 0 and saturate at all-ones.
  - Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Structure
- Shared package ooo_pkg holds:
  - ROB_DEPTH, PHYS_W, ARCH_W.
  - ROB entry bit-position constants (ROB_VALID_BIT, ROB_NEWPHYS_LSB, ROB_OLDPHYS_LSB, ROB_ARCH_LSB, ROB_COMPLETE_BIT).
  - rob_entry_t packed struct.
  - retire_state_t enum.
- One sub-module: rob_slot_check. It is combinational, instantiated twice. It takes an entry and its complete bit and produces eligible, arch, new phys, old phys and free-enable.

## Test plan
- Reset, all rob invalid -> retire_valid=00, head_idx=0, state S_IDLE for 10 cycles.
- Entries 0,1 valid, complete={0:1, 1:1}, entry0 arch 5 old 12 new 33 -> next cycle:
  - retire_valid=11, retire_rob={0,1}, free_phys[0]=12, commit_arch[0]=5, commit_phys[0]=33.
  - head_idx=2.
- Entry 2 valid but not complete, entry 3 complete -> retire_valid=00, head stays 2 (no out-of-order commit). Set complete[2] -> slots 2 and 3 retire.
- head=15, entries 15 and 0 complete -> retire_rob={15,0}, head_idx=1.
- Entry with arch dest 0 retires -> retire_valid[0]=1, free_valid[0]=0.
- Flush asserted with head=6 and eligible entries -> no retirement, head_idx=0 next cycle. rst asserted mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/ooo_pkg.sv
// ooo_pkg: shared widths, ROB entry layout and retire FSM encoding
// for the out-of-order core.
package ooo_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int PHYS_W    = 6;
    localparam int ARCH_W    = 5;

    localparam int ROB_VALID_BIT    = 0;
    localparam int ROB_NEWPHYS_LSB  = 1;
    localparam int ROB_OLDPHYS_LSB  = ROB_NEWPHYS_LSB + PHYS_W;
    localparam int ROB_ARCH_LSB     = ROB_OLDPHYS_LSB + PHYS_W;
    localparam int ROB_COMPLETE_BIT = ROB_ARCH_LSB + ARCH_W;
    localparam int ROB_W            = ROB_COMPLETE_BIT + 1;

    typedef struct packed {
        logic              complete;
        logic [ARCH_W-1:0] arch;
        logic [PHYS_W-1:0] old_phys;
        logic [PHYS_W-1:0] new_phys;
        logic              valid;
    } rob_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_COMMIT,
        S_FLUSH
    } retire_state_t;

    function automatic logic [31:0] sat_add32(
        input logic [31:0] a,
        input logic [1:0]  b
    );
        logic [32:0] s;
        s = {1'b0, a} + {31'd0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/rob_slot_check.sv
// rob_slot_check: decodes one ROB entry and decides whether it may retire.
// The entry's own complete bit is stale; the separate complete flag is used.
module rob_slot_check
    import ooo_pkg::*;
(
    input  logic [ROB_W-1:0]  entry,
    input  logic              complete,
    output logic              eligible,
    output logic [ARCH_W-1:0] arch,
    output logic [PHYS_W-1:0] new_phys,
    output logic [PHYS_W-1:0] old_phys,
    output logic              free_en
);

    logic unused_complete;

    assign unused_complete = entry[ROB_COMPLETE_BIT];

    assign eligible = entry[ROB_VALID_BIT] & complete;
    assign arch     = entry[ROB_ARCH_LSB +: ARCH_W];
    assign new_phys = entry[ROB_NEWPHYS_LSB +: PHYS_W];
    assign old_phys = entry[ROB_OLDPHYS_LSB +: PHYS_W];
    // x0 never owns a physical register, so nothing is freed for it
    assign free_en  = (arch != '0);

endmodule

// File: rtl/rob_retire.sv
// rob_retire: in-order commit of up to two completed ROB entries per cycle.
// Optional ROB_RETIRE_STATS_EN adds saturating retired/stall counters.
module rob_retire #(
    parameter int ROB_DEPTH = ooo_pkg::ROB_DEPTH,
    parameter int PHYS_W    = ooo_pkg::PHYS_W,
    parameter int ARCH_W    = ooo_pkg::ARCH_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ROB_DEPTH*ooo_pkg::ROB_W-1:0] rob,
    input  logic [ROB_DEPTH-1:0]                complete_array,
    input  logic                                flush,
    output logic [1:0]                          retire_valid,
    output logic [2*$clog2(ROB_DEPTH)-1:0]      retire_rob,
    output logic [1:0]                          free_valid,
    output logic [2*PHYS_W-1:0]                 free_phys,
    output logic [2*ARCH_W-1:0]                 commit_arch,
    output logic [2*PHYS_W-1:0]                 commit_phys,
    output logic [$clog2(ROB_DEPTH)-1:0]        head_idx
`ifdef ROB_RETIRE_STATS_EN
    ,
    output logic [31:0]                         retired_count,
    output logic [31:0]                         stall_count
`endif
);

    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int EW    = ooo_pkg::ROB_W;

    ooo_pkg::retire_state_t state_q, state_d;
    ooo_pkg::rob_entry_t    e0, e1;

    logic [IDX_W-1:0]  head, head1, head_d;
    logic [1:0]        rv_d;
    logic              elig0, elig1_raw, elig1;
    logic              fe0, fe1;
    logic [ARCH_W-1:0] a0, a1;
    logic [PHYS_W-1:0] np0, np1, op0, op1;

    assign head1 = head + IDX_W'(1);
    assign e0    = rob[head  * EW +: EW];
    assign e1    = rob[head1 * EW +: EW];

    rob_slot_check u_slot0 (
        .entry    (e0),
        .complete (complete_array[head]),
        .eligible (elig0),
        .arch     (a0),
        .new_phys (np0),
        .old_phys (op0),
        .free_en  (fe0)
    );

    rob_slot_check u_slot1 (
        .entry    (e1),
        .complete (complete_array[head1]),
        .eligible (elig1_raw),
        .arch     (a1),
        .new_phys (np1),
        .old_phys (op1),
        .free_en  (fe1)
    );

    // slot1 may only follow slot0 so commit stays in program order
    assign elig1 = elig0 & elig1_raw;

    always_comb begin
        state_d = ooo_pkg::S_IDLE;
        rv_d    = 2'b00;
        priority case (1'b1)
            flush: begin
                state_d = ooo_pkg::S_FLUSH;
            end
            (state_q == ooo_pkg::S_FLUSH): begin
                state_d = ooo_pkg::S_IDLE;
            end
            elig0: begin
                state_d = ooo_pkg::S_COMMIT;
                if (elig1) rv_d = 2'b11;
                else       rv_d = 2'b01;
            end
            e0.valid: begin
                state_d = ooo_pkg::S_WAIT;
            end
            default: begin
                state_d = ooo_pkg::S_IDLE;
            end
        endcase
    end

    assign head_d = flush ? '0
                  : head + IDX_W'(rv_d[0]) + IDX_W'(rv_d[1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ooo_pkg::S_IDLE;
            head         <= '0;
            retire_valid <= '0;
            free_valid   <= '0;
            retire_rob   <= '0;
            free_phys    <= '0;
            commit_arch  <= '0;
            commit_phys  <= '0;
        end else begin
            state_q      <= state_d;
            head         <= head_d;
            retire_valid <= rv_d;
            free_valid   <= rv_d & {fe1, fe0};
            retire_rob   <= {head1, head};
            free_phys    <= {op1, op0};
            commit_arch  <= {a1, a0};
            commit_phys  <= {np1, np0};
        end
    end

    assign head_idx = head;

`ifdef ROB_RETIRE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_count <= '0;
            stall_count   <= '0;
        end else begin
            retired_count <= ooo_pkg::sat_add32(retired_count,
                {1'b0, retire_valid[0]} + {1'b0, retire_valid[1]});
            stall_count   <= ooo_pkg::sat_add32(stall_count,
                {1'b0, state_q == ooo_pkg::S_WAIT});
        end
    end
`endif

endmodule

// File: tb/tb_rob_retire.sv
// tb_rob_retire: directed scenarios plus randomized traffic checked
// against a queue-of-entries model of in-order retirement.
module tb_rob_retire;

    localparam int D = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [D*19-1:0] rob;
    logic [D-1:0]  complete_array;
    logic [1:0]    retire_valid, free_valid;
    logic [7:0]    retire_rob;
    logic [11:0]   free_phys, commit_phys;
    logic [9:0]    commit_arch;
    logic [3:0]    head_idx;
`ifdef ROB_RETIRE_STATS_EN
    logic [31:0]   retired_count, stall_count;
`endif

    int nvec = 0;
    int nerr = 0;

    bit m_valid[D];
    bit m_comp[D];
    bit m_junk[D];
    int m_arch[D];
    int m_old[D];
    int m_new[D];

    always #5 clk = ~clk;

    rob_retire dut (
        .clk            (clk),
        .rst            (rst),
        .rob            (rob),
        .complete_array (complete_array),
        .flush          (flush),
        .retire_valid   (retire_valid),
        .retire_rob     (retire_rob),
        .free_valid     (free_valid),
        .free_phys      (free_phys),
        .commit_arch    (commit_arch),
        .commit_phys    (commit_phys),
        .head_idx       (head_idx)
`ifdef ROB_RETIRE_STATS_EN
        ,
        .retired_count  (retired_count),
        .stall_count    (stall_count)
`endif
    );

    task automatic drive();
        for (int i = 0; i < D; i++) begin
            rob[i*19 +: 19] = {m_junk[i], 5'(m_arch[i]), 6'(m_old[i]),
                               6'(m_new[i]), m_valid[i]};
            complete_array[i] = m_comp[i];
        end
    endtask

    task automatic set_ent(input int i, input int a, input int o,
                           input int n, input bit c);
        m_valid[i] = 1'b1;
        m_comp[i]  = c;
        m_arch[i]  = a;
        m_old[i]   = o;
        m_new[i]   = n;
        m_junk[i]  = ~c;
        drive();
    endtask

    task automatic clear_all();
        for (int i = 0; i < D; i++) begin
            m_valid[i] = 1'b0;
            m_comp[i]  = 1'b0;
            m_junk[i]  = 1'b0;
            m_arch[i]  = 0;
            m_old[i]   = 0;
            m_new[i]   = 0;
        end
        drive();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_all();
        rst = 1'b1;
        #1;
        nvec++;
        if ({retire_valid, free_valid, retire_rob, free_phys,
             commit_arch, commit_phys, head_idx} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {retire_valid, free_valid, retire_rob, free_phys,
                      commit_arch, commit_phys, head_idx});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            nvec++;
            if (retire_valid !== 2'b00 || head_idx !== 4'd0) begin
                nerr++;
                $display("FAIL idle_%0d: got rv=%b head=%0d expected rv=00 head=0",
                         c, retire_valid, head_idx);
            end
        end
    endtask

    task automatic test_pair();
        set_ent(0, 5, 12, 33, 1'b1);
        set_ent(1, 7, 3, 40, 1'b1);
        step();
        clear_all();
        nvec++;
        if (retire_valid !== 2'b11 || retire_rob !== 8'h10) begin
            nerr++;
            $display("FAIL pair_retire: got rv=%b rob=%h expected rv=11 rob=10",
                     retire_valid, retire_rob);
        end
        nvec++;
        if (free_phys !== {6'd3, 6'd12} || free_valid !== 2'b11) begin
            nerr++;
            $display("FAIL pair_free: got fv=%b fp=%h expected fv=11 fp=%h",
                     free_valid, free_phys, {6'd3, 6'd12});
        end
        nvec++;
        if (commit_arch !== {5'd7, 5'd5} || commit_phys !== {6'd40, 6'd33}) begin
            nerr++;
            $display("FAIL pair_commit: got ca=%h cp=%h expected ca=%h cp=%h",
                     commit_arch, commit_phys, {5'd7, 5'd5}, {6'd40, 6'd33});
        end
        nvec++;
        if (head_idx !== 4'd2) begin
            nerr++;
            $display("FAIL pair_head: got %0d expected 2", head_idx);
        end
    endtask

    task automatic test_in_order();
        set_ent(2, 1, 2, 3, 1'b0);
        set_ent(3, 4, 5, 6, 1'b1);
        for (int c = 0; c < 2; c++) begin
            step();
            nvec++;
            if (retire_valid !== 2'b00 || head_idx !== 4'd2) begin
                nerr++;
                $display("FAIL in_order_hold: got rv=%b head=%0d expected rv=00 head=2",
                         retire_valid, head_idx);
            end
        end
        m_comp[2] = 1'b1;
        drive();
        step();
        clear_all();
        nvec++;
        if (retire_valid !== 2'b11 || retire_rob !== 8'h32 || head_idx !== 4'd4) begin
            nerr++;
            $display("FAIL in_order_go: got rv=%b rob=%h head=%0d expected rv=11 rob=32 head=4",
                     retire_valid, retire_rob, head_idx);
        end
    endtask

    task automatic test_wrap();
        for (int h = 4; h < 15; h++) begin
            set_ent(h, h, h + 1, h + 2, 1'b1);
            step();
            clear_all();
            nvec++;
            if (retire_valid !== 2'b01 || free_valid !== 2'b01 ||
                retire_rob[3:0] !== 4'(h) || head_idx !== 4'(h + 1)) begin
                nerr++;
                $display("FAIL single_%0d: got rv=%b fv=%b rob=%h head=%0d",
                         h, retire_valid, free_valid, retire_rob, head_idx);
            end
        end
        set_ent(15, 9, 10, 11, 1'b1);
        set_ent(0, 12, 13, 14, 1'b1);
        step();
        clear_all();
        nvec++;
        if (retire_valid !== 2'b11 || retire_rob !== 8'h0f || head_idx !== 4'd1) begin
            nerr++;
            $display("FAIL wrap: got rv=%b rob=%h head=%0d expected rv=11 rob=0f head=1",
                     retire_valid, retire_rob, head_idx);
        end
    endtask

    task automatic test_arch0();
        set_ent(1, 0, 20, 21, 1'b1);
        step();
        clear_all();
        nvec++;
        if (retire_valid !== 2'b01 || free_valid !== 2'b00 ||
            commit_arch[4:0] !== 5'd0 || commit_phys[5:0] !== 6'd21 ||
            head_idx !== 4'd2) begin
            nerr++;
            $display("FAIL arch0: got rv=%b fv=%b ca=%h cp=%h head=%0d",
                     retire_valid, free_valid, commit_arch, commit_phys, head_idx);
        end
    endtask

    task automatic test_flush();
        for (int p = 0; p < 2; p++) begin
            set_ent(2 + 2*p, 3, 4, 5, 1'b1);
            set_ent(3 + 2*p, 6, 7, 8, 1'b1);
            step();
            clear_all();
            nvec++;
            if (retire_valid !== 2'b11 || head_idx !== 4'(4 + 2*p)) begin
                nerr++;
                $display("FAIL pre_flush_%0d: got rv=%b head=%0d", p,
                         retire_valid, head_idx);
            end
        end
        set_ent(6, 1, 2, 3, 1'b1);
        set_ent(7, 4, 5, 6, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        clear_all();
        nvec++;
        if (retire_valid !== 2'b00 || free_valid !== 2'b00 || head_idx !== 4'd0) begin
            nerr++;
            $display("FAIL flush: got rv=%b fv=%b head=%0d expected rv=00 fv=00 head=0",
                     retire_valid, free_valid, head_idx);
        end
        step();
        nvec++;
        if (retire_valid !== 2'b00 || head_idx !== 4'd0) begin
            nerr++;
            $display("FAIL post_flush: got rv=%b head=%0d expected rv=00 head=0",
                     retire_valid, head_idx);
        end
    endtask

    task automatic test_reset_mid();
        set_ent(0, 3, 4, 5, 1'b1);
        set_ent(1, 6, 7, 8, 1'b1);
        step();
        nvec++;
        if (retire_valid !== 2'b11) begin
            nerr++;
            $display("FAIL mid_pre: got rv=%b expected 11", retire_valid);
        end
        rst = 1'b1;
        #1;
        nvec++;
        if ({retire_valid, free_valid, retire_rob, free_phys,
             commit_arch, commit_phys, head_idx} !== '0) begin
            nerr++;
            $display("FAIL mid_reset: got %0h expected 0",
                     {retire_valid, free_valid, retire_rob, free_phys,
                      commit_arch, commit_phys, head_idx});
        end
        clear_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        int hm = 0;
        int h0, h1;
        bit e0, e1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < D; i++) begin
                if (!m_valid[i]) begin
                    m_junk[i] = 1'($urandom_range(1));
                    m_comp[i] = 1'($urandom_range(1));
                    if ($urandom_range(2) == 0) begin
                        m_valid[i] = 1'b1;
                        m_arch[i]  = ($urandom_range(3) == 0) ? 0
                                   : int'($urandom_range(31));
                        m_old[i]   = int'($urandom_range(63));
                        m_new[i]   = int'($urandom_range(63));
                    end
                end else if (!m_comp[i]) begin
                    m_comp[i] = 1'($urandom_range(1));
                end
            end
            drive();
            h0 = hm;
            h1 = (hm + 1) % D;
            e0 = m_valid[h0] && m_comp[h0];
            e1 = e0 && m_valid[h1] && m_comp[h1];
            step();
            nvec++;
            if (retire_valid !== {e1, e0} || head_idx !== 4'((hm + e0 + e1) % D)) begin
                nerr++;
                $display("FAIL rand_%0d_ctl: got rv=%b head=%0d expected rv=%b head=%0d",
                         c, retire_valid, head_idx, {e1, e0}, (hm + e0 + e1) % D);
            end
            nvec++;
            if (free_valid !== {e1 && m_arch[h1] != 0, e0 && m_arch[h0] != 0}) begin
                nerr++;
                $display("FAIL rand_%0d_fv: got %b expected %b", c, free_valid,
                         {e1 && m_arch[h1] != 0, e0 && m_arch[h0] != 0});
            end
            if (e0) begin
                nvec++;
                if (retire_rob[3:0] !== 4'(h0) || commit_arch[4:0] !== 5'(m_arch[h0]) ||
                    commit_phys[5:0] !== 6'(m_new[h0]) || free_phys[5:0] !== 6'(m_old[h0])) begin
                    nerr++;
                    $display("FAIL rand_%0d_s0: got rob=%0d ca=%0d cp=%0d fp=%0d expected %0d %0d %0d %0d",
                             c, retire_rob[3:0], commit_arch[4:0], commit_phys[5:0],
                             free_phys[5:0], h0, m_arch[h0], m_new[h0], m_old[h0]);
                end
                m_valid[h0] = 1'b0;
                m_comp[h0]  = 1'b0;
            end
            if (e1) begin
                nvec++;
                if (retire_rob[7:4] !== 4'(h1) || commit_arch[9:5] !== 5'(m_arch[h1]) ||
                    commit_phys[11:6] !== 6'(m_new[h1]) || free_phys[11:6] !== 6'(m_old[h1])) begin
                    nerr++;
                    $display("FAIL rand_%0d_s1: got rob=%0d ca=%0d cp=%0d fp=%0d expected %0d %0d %0d %0d",
                             c, retire_rob[7:4], commit_arch[9:5], commit_phys[11:6],
                             free_phys[11:6], h1, m_arch[h1], m_new[h1], m_old[h1]);
                end
                m_valid[h1] = 1'b0;
                m_comp[h1]  = 1'b0;
            end
            hm = (hm + e0 + e1) % D;
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_in_order();
        test_wrap();
        test_arch0();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
